// File: rtl/fpu_addsub_sched.sv
// Round-robin scheduler for the shared single-precision add/sub datapath.
// Holds the granted operands on the datapath for FPU_LAT cycles, then returns the tagged result.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester per accept
// EXEC  | operands held on the datapath, cnt counts down to the sample edge
// RESP  | result captured, waiting for rsp_ready
module fpu_addsub_sched #(
    parameter int FPU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [31:0]      req_a_0,
    input  logic [31:0]      req_a_1,
    input  logic [31:0]      req_b_0,
    input  logic [31:0]      req_b_1,
    input  logic             req_op_0,
    input  logic             req_op_1,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_add_sub,
    input  logic [31:0]      fpu_result,
    input  logic             fpu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(FPU_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       rr_ptr;
    logic [3:0] cnt;
    logic       op_id;
    logic       grant_valid;
    logic       grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_0 && req_valid_1) begin
                    grant_valid = 1'b1;
                    grant_id    = rr_ptr;
                end else if (req_valid_0) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (req_valid_1) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                if (grant_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign req_ready_0 = rst_n && grant_valid && !grant_id;
    assign req_ready_1 = rst_n && grant_valid && grant_id;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= 1'b0;
            cnt          <= 4'd0;
            op_id        <= 1'b0;
            fpu_a        <= 32'd0;
            fpu_b        <= 32'd0;
            fpu_add_sub  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= 32'd0;
            rsp_overflow <= 1'b0;
            op_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        fpu_a       <= grant_id ? req_a_1 : req_a_0;
                        fpu_b       <= grant_id ? req_b_1 : req_b_0;
                        fpu_add_sub <= grant_id ? req_op_1 : req_op_0;
                        op_id       <= grant_id;
                        cnt         <= LAT_M1;
                        rr_ptr      <= ~grant_id;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result   <= fpu_result;
                        rsp_overflow <= fpu_overflow;
                        rsp_id       <= op_id;
                        rsp_valid    <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (op_count != {CNT_W{1'b1}}) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Bench for fpu_addsub_sched: two instances (FPU_LAT=1/CNT_W=16 and FPU_LAT=4/CNT_W=2)
// share stimulus and are checked each cycle against a transaction-level model.
module tb_fpu_addsub_sched;

    logic        clk;
    logic        rst_n;
    logic        v0, v1, op0, op1, fovf, rsp_ready;
    logic [31:0] a0, a1, b0, b1, fres;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        fop  [2];
    logic        rv   [2];
    logic        rid  [2];
    logic        rovf [2];
    logic        bsy  [2];
    logic [31:0] fa   [2];
    logic [31:0] fb   [2];
    logic [31:0] rres [2];
    logic [15:0] opc_a;
    logic [1:0]  opc_b;

    fpu_addsub_sched #(.FPU_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(v0), .req_valid_1(v1),
        .req_ready_0(rdy0[0]), .req_ready_1(rdy1[0]),
        .req_a_0(a0), .req_a_1(a1), .req_b_0(b0), .req_b_1(b1),
        .req_op_0(op0), .req_op_1(op1),
        .fpu_a(fa[0]), .fpu_b(fb[0]), .fpu_add_sub(fop[0]),
        .fpu_result(fres), .fpu_overflow(fovf),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]),
        .rsp_result(rres[0]), .rsp_overflow(rovf[0]),
        .busy(bsy[0]), .op_count(opc_a)
    );

    fpu_addsub_sched #(.FPU_LAT(4), .CNT_W(2)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(v0), .req_valid_1(v1),
        .req_ready_0(rdy0[1]), .req_ready_1(rdy1[1]),
        .req_a_0(a0), .req_a_1(a1), .req_b_0(b0), .req_b_1(b1),
        .req_op_0(op0), .req_op_1(op1),
        .fpu_a(fa[1]), .fpu_b(fb[1]), .fpu_add_sub(fop[1]),
        .fpu_result(fres), .fpu_overflow(fovf),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]),
        .rsp_result(rres[1]), .rsp_overflow(rovf[1]),
        .busy(bsy[1]), .op_count(opc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: an operation is "in flight" from its accept edge until the edge
    // lat cycles later, then a response is pending until it is handed over.
    int          lat  [2] = '{1, 4};
    int          cmax [2] = '{65535, 3};
    bit          m_rr  [2];
    bit          m_inf [2];
    bit          m_rv  [2];
    bit          m_id  [2];
    bit          m_cid [2];
    bit          m_op  [2];
    bit          m_ovf [2];
    logic [31:0] m_a   [2];
    logic [31:0] m_b   [2];
    logic [31:0] m_res [2];
    int          m_samp[2];
    int          m_cnt [2];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc%0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready(input int d, input int g);
        bit mine, other;
        mine  = (g == 0) ? v0 : v1;
        other = (g == 0) ? v1 : v0;
        return rst_n && !m_inf[d] && !m_rv[d] && mine && (!other || (m_rr[d] == g[0]));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rr[d] = 0; m_inf[d] = 0; m_rv[d] = 0; m_id[d] = 0; m_cid[d] = 0;
            m_op[d] = 0; m_ovf[d] = 0; m_a[d] = 0; m_b[d] = 0; m_res[d] = 0;
            m_samp[d] = 0; m_cnt[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit acc0, acc1, samp, rh;
            acc0 = m_ready(d, 0);
            acc1 = m_ready(d, 1);
            samp = m_inf[d] && (cyc == m_samp[d]);
            rh   = m_rv[d] && rsp_ready;
            if (acc0 || acc1) begin
                m_a[d]    = acc1 ? a1 : a0;
                m_b[d]    = acc1 ? b1 : b0;
                m_op[d]   = acc1 ? op1 : op0;
                m_cid[d]  = acc1;
                m_inf[d]  = 1;
                m_samp[d] = cyc + lat[d];
                m_rr[d]   = !acc1;
            end
            if (samp) begin
                m_res[d] = fres;
                m_ovf[d] = fovf;
                m_id[d]  = m_cid[d];
                m_rv[d]  = 1;
                m_inf[d] = 0;
            end
            if (rh) begin
                m_rv[d] = 0;
                if (m_cnt[d] < cmax[d]) m_cnt[d]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk("req_ready_0", d, 32'(rdy0[d]), 32'(m_ready(d, 0)));
            chk("req_ready_1", d, 32'(rdy1[d]), 32'(m_ready(d, 1)));
            chk("fpu_a", d, fa[d], m_a[d]);
            chk("fpu_b", d, fb[d], m_b[d]);
            chk("fpu_add_sub", d, 32'(fop[d]), 32'(m_op[d]));
            chk("rsp_valid", d, 32'(rv[d]), 32'(m_rv[d]));
            chk("rsp_id", d, 32'(rid[d]), 32'(m_id[d]));
            chk("rsp_result", d, rres[d], m_res[d]);
            chk("rsp_overflow", d, 32'(rovf[d]), 32'(m_ovf[d]));
            chk("busy", d, 32'(bsy[d]), 32'(m_inf[d] || m_rv[d]));
            chk("op_count", d, (d == 0) ? 32'(opc_a) : 32'(opc_b), 32'(m_cnt[d]));
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        if (!rst_n) model_reset();
        compare_all();
        @(posedge clk);
        if (rst_n) model_edge();
        cyc++;
        #1;
    endtask

    task automatic wait_rsp(input int d, input int limit);
        int n = 0;
        while (!rv[d] && n < limit) begin
            step();
            n++;
        end
        if (!rv[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_rsp dut%0d: got timeout expected rsp_valid within %0d cycles", d, limit);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        v0 = 0; v1 = 0; op0 = 0; op1 = 0; fovf = 0; rsp_ready = 0;
        a0 = 0; a1 = 0; b0 = 0; b1 = 0; fres = 0;
    endtask

    initial begin
        bit grants[$];
        int exp_g [4]  = '{0, 1, 0, 1};
        int exp_sat[5] = '{1, 2, 3, 3, 3};

        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_ready", 0, 32'(rdy0[0]), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single request on requester 0.
        v0 = 1; a0 = 32'h3F80_0000; b0 = 32'h4000_0000; op0 = 0; fres = 32'h4040_0000;
        #1;
        chk("single_ready0", 0, 32'(rdy0[0]), 32'd1);
        step();
        v0 = 0;
        #1;
        chk("single_ready_pulse", 0, 32'(rdy0[0]), 32'd0);
        chk("single_rv_early", 0, 32'(rv[0]), 32'd0);
        chk("single_fpu_a", 0, fa[0], 32'h3F80_0000);
        step();
        chk("single_rv", 0, 32'(rv[0]), 32'd1);
        chk("single_rid", 0, 32'(rid[0]), 32'd0);
        chk("single_result", 0, rres[0], 32'h4040_0000);
        rsp_ready = 1;
        step();
        chk("single_count", 0, 32'(opc_a), 32'd1);
        for (int k = 0; k < 6; k++) step();

        // Contention: both requesters valid continuously.
        do_reset();
        rsp_ready = 1;
        for (int k = 0; k < 24; k++) begin
            v0 = 1; v1 = 1;
            a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
            op0 = 1'($urandom); op1 = 1'($urandom); fres = $urandom;
            #1;
            if (rdy0[0] || rdy1[0]) grants.push_back(rdy1[0]);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            chk("contention_grant", 0, (grants.size() > k) ? 32'(grants[k]) : 32'hFFFF_FFFF, 32'(exp_g[k]));
        end

        // Result sampled exactly FPU_LAT edges after accept.
        idle_inputs();
        do_reset();
        v0 = 1; a0 = 32'h1234_5678; b0 = 32'h9ABC_DEF0; op0 = 1;
        for (int j = 0; j < 6; j++) begin
            fres = 32'(100 + j);
            step();
            v0 = 0;
            if (j == 1) chk("lat1_sample", 0, rres[0], 32'd101);
            if (j == 3) chk("lat4_fpu_a_held", 1, fa[1], 32'h1234_5678);
            if (j == 4) chk("lat4_sample", 1, rres[1], 32'd104);
        end
        rsp_ready = 1;
        step();
        step();

        // Backpressure with requester 1 waiting.
        idle_inputs();
        do_reset();
        v1 = 1; a1 = 32'hC000_0000; b1 = 32'h3F00_0000;
        wait_rsp(0, 10);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_ready1", 0, 32'(rdy1[0]), 32'd0);
            chk("bp_busy", 0, 32'(bsy[0]), 32'd1);
        end
        rsp_ready = 1;
        step();
        chk("bp_grant_after", 0, 32'(rdy1[0]), 32'd1);
        v1 = 0;
        for (int k = 0; k < 8; k++) step();

        // Reset during the second EXEC cycle of the FPU_LAT=4 instance.
        idle_inputs();
        do_reset();
        v0 = 1; a0 = 32'h4120_0000;
        step();
        v0 = 0;
        step();
        rst_n = 0;
        #1;
        chk("midreset_busy", 1, 32'(bsy[1]), 32'd0);
        chk("midreset_fpu_a", 1, fa[1], 32'd0);
        chk("midreset_rv", 0, 32'(rv[0]), 32'd0);
        step();
        rst_n = 1;
        v0 = 1; v1 = 1;
        #1;
        chk("midreset_grant0", 1, 32'(rdy0[1]), 32'd1);
        chk("midreset_grant1", 1, 32'(rdy1[1]), 32'd0);
        v0 = 0; v1 = 0;
        for (int k = 0; k < 8; k++) step();

        // Saturation of the 2-bit counter, overflow flag pass-through.
        idle_inputs();
        do_reset();
        v0 = 1; fovf = 1; rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(1, 20);
            chk("sat_overflow", 1, 32'(rovf[1]), 32'd1);
            step();
            chk("sat_count", 1, 32'(opc_b), 32'(exp_sat[i]));
        end
        idle_inputs();
        step();

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
            op0 = 1'($urandom); op1 = 1'($urandom);
            fres = $urandom; fovf = 1'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        rst_n = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1000000");
        $fatal(1);
    end

endmodule
